// File: rtl/flash_arb_pkg.sv
// Shared types and defaults for the flash read-port arbiter.
package flash_arb_pkg;

    localparam int unsigned NUM_REQ_DEF = 4;
    localparam int unsigned LEN_W_DEF   = 24;
    localparam int unsigned ADDR_W_DEF  = 25;
    localparam int unsigned TO_W_DEF    = 20;
    localparam int unsigned DATA_W      = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_XFER    = 2'd2,
        ST_RELEASE = 2'd3
    } arb_state_e;

endpackage

// File: rtl/flash_rd_arbiter_if.sv
// Requester-side and flash-side signals of the shared flash read port.
interface flash_rd_arbiter_if
    import flash_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = NUM_REQ_DEF,
    parameter int unsigned LEN_W   = LEN_W_DEF,
    parameter int unsigned ADDR_W  = ADDR_W_DEF
) ();

    logic [NUM_REQ-1:0]        req_rden;
    logic [NUM_REQ*LEN_W-1:0]  req_length;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ-1:0]        req_grant;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_last;
    logic [DATA_W-1:0]         req_data;
    logic [NUM_REQ-1:0]        req_error;
    logic                      flash_rden;
    logic [LEN_W-1:0]          flash_length;
    logic [ADDR_W-1:0]         flash_addr;
    logic                      flash_valid;
    logic                      flash_last;
    logic [DATA_W-1:0]         flash_data;
    logic                      busy;

    modport master (
        input  req_rden, req_length, req_addr, flash_valid, flash_last, flash_data,
        output req_grant, req_valid, req_last, req_data, req_error,
               flash_rden, flash_length, flash_addr, busy
    );

    modport slave (
        output req_rden, req_length, req_addr, flash_valid, flash_last, flash_data,
        input  req_grant, req_valid, req_last, req_data, req_error,
               flash_rden, flash_length, flash_addr, busy
    );

endinterface

// File: rtl/rr_arbiter.sv
// Picks one pending requester: round-robin from ptr (wrapping) or fixed lowest-index priority.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter bit          ARB_RR  = 1'b1
) (
    input  logic [NUM_REQ-1:0]         pending,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [NUM_REQ-1:0]         grant_c,
    output logic [$clog2(NUM_REQ)-1:0] idx_c,
    output logic                       any_c
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] idx;
    logic             found;

    assign any_c = |pending;

    // Scan candidates in priority order starting at ptr (or at 0 in fixed mode)
    always_comb begin
        grant_c = '0;
        idx_c   = '0;
        sum     = '0;
        idx     = '0;
        found   = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (ARB_RR) begin
                sum = {1'b0, ptr} + (IDX_W+1)'(k);
                if (sum >= (IDX_W+1)'(NUM_REQ)) begin
                    sum = sum - (IDX_W+1)'(NUM_REQ);
                end
                idx = IDX_W'(sum);
            end else begin
                idx = IDX_W'(k);
            end
            if (!found && pending[idx]) begin
                grant_c[idx] = 1'b1;
                idx_c        = idx;
                found        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/flash_rd_arbiter.sv
// Shares one flash read-command port between NUM_REQ load engines; steers returned bytes
// to the owner and flags zero length, byte-count mismatch and return timeout.
module flash_rd_arbiter
    import flash_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = NUM_REQ_DEF,
    parameter int unsigned LEN_W   = LEN_W_DEF,
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter bit          ARB_RR  = 1'b1,
    parameter int unsigned TO_W    = TO_W_DEF
) (
    input logic                sys_clk,
    input logic                glbl_rst,
    flash_rd_arbiter_if.master bus
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    arb_state_e state_q, state_d;

    logic [NUM_REQ-1:0] pending_q;
    logic [NUM_REQ-1:0] take_c;
    logic [NUM_REQ-1:0] pend_clr_c;
    logic [LEN_W-1:0]   len_in  [NUM_REQ];
    logic [LEN_W-1:0]   len_q   [NUM_REQ];
    logic [ADDR_W-1:0]  addr_in [NUM_REQ];
    logic [ADDR_W-1:0]  addr_q  [NUM_REQ];

    logic [NUM_REQ-1:0] arb_grant_c;
    logic [IDX_W-1:0]   arb_idx_c;
    logic               arb_any_c;
    logic [IDX_W-1:0]   ptr_q, ptr_d;

    logic [LEN_W-1:0]   byte_cnt_q, byte_cnt_d, cnt_inc_c;
    logic [TO_W-1:0]    to_cnt_q, to_cnt_d;

    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [NUM_REQ-1:0] valid_q, valid_d;
    logic [NUM_REQ-1:0] last_q, last_d;
    logic [NUM_REQ-1:0] error_q, error_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic               rden_q, rden_d;
    logic [LEN_W-1:0]   flen_q, flen_d;
    logic [ADDR_W-1:0]  faddr_q, faddr_d;
    logic               busy_q, busy_d;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
        assign len_in[g]  = bus.req_length[g*LEN_W +: LEN_W];
        assign addr_in[g] = bus.req_addr[g*ADDR_W +: ADDR_W];
    end

    // A repeat pulse while pending or while owning the port is dropped
    assign take_c    = bus.req_rden & ~pending_q & ~grant_q;
    assign cnt_inc_c = byte_cnt_q + LEN_W'(1);

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ARB_RR  (ARB_RR)
    ) u_arb (
        .pending (pending_q),
        .ptr     (ptr_q),
        .grant_c (arb_grant_c),
        .idx_c   (arb_idx_c),
        .any_c   (arb_any_c)
    );

    // Request capture: pending flags plus latched length/address per requester
    always_ff @(posedge sys_clk) begin
        if (glbl_rst) begin
            pending_q <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                len_q[i]  <= '0;
                addr_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (take_c[i]) begin
                    pending_q[i] <= 1'b1;
                    len_q[i]     <= len_in[i];
                    addr_q[i]    <= addr_in[i];
                end else if (pend_clr_c[i]) begin
                    pending_q[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (glbl_rst) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            byte_cnt_q <= '0;
            to_cnt_q   <= '0;
            grant_q    <= '0;
            valid_q    <= '0;
            last_q     <= '0;
            error_q    <= '0;
            data_q     <= '0;
            rden_q     <= 1'b0;
            flen_q     <= '0;
            faddr_q    <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            byte_cnt_q <= byte_cnt_d;
            to_cnt_q   <= to_cnt_d;
            grant_q    <= grant_d;
            valid_q    <= valid_d;
            last_q     <= last_d;
            error_q    <= error_d;
            data_q     <= data_d;
            rden_q     <= rden_d;
            flen_q     <= flen_d;
            faddr_q    <= faddr_d;
            busy_q     <= busy_d;
        end
    end

    // Next state and next registered outputs; pulses default low every cycle
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        byte_cnt_d = byte_cnt_q;
        to_cnt_d   = to_cnt_q;
        grant_d    = grant_q;
        valid_d    = '0;
        last_d     = '0;
        error_d    = '0;
        data_d     = data_q;
        rden_d     = 1'b0;
        flen_d     = flen_q;
        faddr_d    = faddr_q;
        pend_clr_c = '0;

        case (state_q)
            ST_IDLE: begin
                if (arb_any_c) begin
                    state_d    = ST_ISSUE;
                    grant_d    = arb_grant_c;
                    pend_clr_c = arb_grant_c;
                    ptr_d      = (arb_idx_c == IDX_W'(NUM_REQ - 1)) ? '0 : arb_idx_c + IDX_W'(1);
                    byte_cnt_d = '0;
                    to_cnt_d   = '0;
                    // Zero-length requests never reach the flash controller
                    if (len_q[arb_idx_c] == '0) begin
                        error_d = arb_grant_c;
                    end else begin
                        rden_d  = 1'b1;
                        flen_d  = len_q[arb_idx_c];
                        faddr_d = addr_q[arb_idx_c];
                    end
                end
            end
            ST_ISSUE: begin
                state_d = rden_q ? ST_XFER : ST_RELEASE;
            end
            ST_XFER: begin
                if (bus.flash_valid) begin
                    valid_d    = grant_q;
                    data_d     = bus.flash_data;
                    byte_cnt_d = cnt_inc_c;
                    to_cnt_d   = '0;
                    if (bus.flash_last) begin
                        last_d  = grant_q;
                        state_d = ST_RELEASE;
                        if (cnt_inc_c != flen_q) begin
                            error_d = grant_q;
                        end
                    end else if (cnt_inc_c == flen_q) begin
                        error_d = grant_q;
                        state_d = ST_RELEASE;
                    end
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                    if (to_cnt_d == '1) begin
                        error_d = grant_q;
                        state_d = ST_RELEASE;
                    end
                end
            end
            ST_RELEASE: begin
                grant_d = '0;
                state_d = ST_IDLE;
            end
            default: begin
                grant_d = '0;
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    assign bus.req_grant    = grant_q;
    assign bus.req_valid    = valid_q;
    assign bus.req_last     = last_q;
    assign bus.req_data     = data_q;
    assign bus.req_error    = error_q;
    assign bus.flash_rden   = rden_q;
    assign bus.flash_length = flen_q;
    assign bus.flash_addr   = faddr_q;
    assign bus.busy         = busy_q;

endmodule
